// File: rtl/grant_vector_decoder.sv
// Turns queued encoded request indices into one-hot grants. Each grant is held
// until the consumer completes a four-phase req/ack handshake.
module grant_vector_decoder #(
   parameter int IDX_W = 3,
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [IDX_W-1:0]         in_idx,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [(2**IDX_W)-1:0]    grant,
   output logic                     grant_valid,
   output logic [IDX_W-1:0]         grant_idx,
   input  logic                     ack,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic [CNT_W-1:0]         grant_count
);

   localparam int GW    = 2**IDX_W;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      WAIT_REL
   } state_t;

   state_t               state_reg;
   state_t               state_next;

   logic [IDX_W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0]     wr_ptr_reg;
   logic [PTR_W-1:0]     rd_ptr_reg;
   logic [LVL_W-1:0]     level_reg;

   logic [GW-1:0]        grant_reg;
   logic                 grant_valid_reg;
   logic [IDX_W-1:0]     grant_idx_reg;
   logic [CNT_W-1:0]     count_reg;

   logic                 push;
   logic                 pop;
   logic                 load;
   logic                 release_grant;
   logic                 fifo_empty;
   logic [IDX_W-1:0]     head_idx;
   logic [GW-1:0]        head_onehot;

   // Readiness depends only on the registered level, so a pop on the same
   // edge never lets a full FIFO accept.
   assign in_ready   = (level_reg != LVL_W'(DEPTH));
   assign fifo_empty = (level_reg == '0);
   assign push       = in_valid && in_ready;
   assign head_idx   = mem[rd_ptr_reg];

   genvar gi;
   generate
      for (gi = 0; gi < GW; gi++) begin : g_dec
         assign head_onehot[gi] = (head_idx == IDX_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= in_idx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   level_reg <= level_reg + LVL_W'(1);
            2'b01:   level_reg <= level_reg - LVL_W'(1);
            default: level_reg <= level_reg;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Pop decisions use the registered level, so an entry pushed into an empty
   // FIFO is only popped on the following edge.
   always_comb begin
      state_next    = state_reg;
      pop           = 1'b0;
      load          = 1'b0;
      release_grant = 1'b0;
      case (state_reg)
         IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               load       = 1'b1;
               state_next = GRANT;
            end
         end
         GRANT: begin
            if (ack) begin
               release_grant = 1'b1;
               state_next    = WAIT_REL;
            end
         end
         WAIT_REL: begin
            if (!ack) begin
               if (!fifo_empty) begin
                  pop        = 1'b1;
                  load       = 1'b1;
                  state_next = GRANT;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_reg       <= '0;
         grant_valid_reg <= 1'b0;
         grant_idx_reg   <= '0;
         count_reg       <= '0;
      end else begin
         if (load) begin
            grant_reg       <= head_onehot;
            grant_valid_reg <= 1'b1;
            grant_idx_reg   <= head_idx;
         end else if (release_grant) begin
            grant_reg       <= '0;
            grant_valid_reg <= 1'b0;
            count_reg       <= count_reg + CNT_W'(1);
         end
      end
   end

   assign grant       = grant_reg;
   assign grant_valid = grant_valid_reg;
   assign grant_idx   = grant_idx_reg;
   assign fifo_level  = level_reg;
   assign grant_count = count_reg;

endmodule

// File: tb/tb_grant_vector_decoder.sv
// Directed bench for grant_vector_decoder: stimulus queues expected indices,
// a negedge monitor pops and compares each grant as it appears.
module tb_grant_vector_decoder;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [2:0] in_idx;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] grant;
   logic       grant_valid;
   logic [2:0] grant_idx;
   logic       ack;
   logic [2:0] fifo_level;
   logic [7:0] grant_count;

   logic [2:0] w_in_idx;
   logic       w_in_valid;
   logic       w_in_ready;
   logic [7:0] w_grant;
   logic       w_grant_valid;
   logic [2:0] w_grant_idx;
   logic       w_ack;
   logic [2:0] w_fifo_level;
   logic [1:0] w_grant_count;

   grant_vector_decoder dut (
      .clk(clk), .rst_n(rst_n), .in_idx(in_idx), .in_valid(in_valid),
      .in_ready(in_ready), .grant(grant), .grant_valid(grant_valid),
      .grant_idx(grant_idx), .ack(ack), .fifo_level(fifo_level),
      .grant_count(grant_count)
   );

   grant_vector_decoder #(.CNT_W(2)) dut_w (
      .clk(clk), .rst_n(rst_n), .in_idx(w_in_idx), .in_valid(w_in_valid),
      .in_ready(w_in_ready), .grant(w_grant), .grant_valid(w_grant_valid),
      .grant_idx(w_grant_idx), .ack(w_ack), .fifo_level(w_fifo_level),
      .grant_count(w_grant_count)
   );

   int         checks = 0;
   int         fails  = 0;
   logic [2:0] exp_q[$];
   logic [7:0] exp_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every rising grant_valid consumes one expected index.
   logic prev_gv = 1'b0;
   always @(negedge clk) begin
      logic [2:0] e;
      logic [7:0] onehot;
      if (!rst_n) begin
         prev_gv = 1'b0;
      end else begin
         if (grant_valid && !prev_gv) begin
            if (exp_q.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_grant: got idx %0d expected none", grant_idx);
            end else begin
               e      = exp_q.pop_front();
               onehot = 8'b1 << e;
               check("grant_onehot", grant, onehot);
               check("grant_idx", grant_idx, e);
               $display("grant idx=%0d grant=%02h", grant_idx, grant);
            end
         end
         if (!grant_valid) check("grant_zero_when_idle", grant, 0);
         prev_gv = grant_valid;
      end
   end

   task automatic push(input logic [2:0] idx);
      int n = 0;
      in_idx   = idx;
      in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check("push_timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      @(negedge clk);
      exp_q.push_back(idx);
      in_valid = 1'b0;
      $display("push idx=%0d level=%0d", idx, fifo_level);
   endtask

   task automatic wait_grant();
      int n = 0;
      while (!grant_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!grant_valid) check("grant_timeout", 0, 1);
   endtask

   task automatic handshake();
      wait_grant();
      ack = 1'b1;
      @(negedge clk);
      exp_cnt = exp_cnt + 8'd1;
      check("ack_clears_valid", grant_valid, 0);
      check("ack_clears_grant", grant, 0);
      check("grant_count", grant_count, exp_cnt);
      ack = 1'b0;
      @(negedge clk);
      $display("handshake done count=%0d", grant_count);
   endtask

   logic [1:0] wrap_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n      = 1'b0;
      in_idx     = '0;
      in_valid   = 1'b0;
      ack        = 1'b0;
      w_in_idx   = '0;
      w_in_valid = 1'b0;
      w_ack      = 1'b0;
      exp_cnt    = '0;
      repeat (2) @(negedge clk);
      check("rst_grant", grant, 0);
      check("rst_grant_valid", grant_valid, 0);
      check("rst_grant_idx", grant_idx, 0);
      check("rst_level", fifo_level, 0);
      check("rst_count", grant_count, 0);
      check("rst_in_ready", in_ready, 1);
      rst_n = 1'b1;
      @(negedge clk);

      // Single request with one-cycle load latency
      in_idx   = 3'd5;
      in_valid = 1'b1;
      @(negedge clk);
      exp_q.push_back(3'd5);
      in_valid = 1'b0;
      check("latency_not_yet", grant_valid, 0);
      @(negedge clk);
      check("latency_valid", grant_valid, 1);
      check("single_grant", grant, 8'h20);
      handshake();
      check("single_idle", grant_valid, 0);

      // Reset mid-grant with three entries queued
      push(3'd1); push(3'd2); push(3'd3); push(3'd4);
      check("pre_rst_valid", grant_valid, 1);
      check("pre_rst_level", fifo_level, 3);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_grant", grant, 0);
      check("async_rst_valid", grant_valid, 0);
      check("async_rst_idx", grant_idx, 0);
      check("async_rst_level", fifo_level, 0);
      check("async_rst_count", grant_count, 0);
      exp_q.delete();
      exp_cnt = '0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_valid", grant_valid, 0);
      check("post_rst_level", fifo_level, 0);
      check("post_rst_in_ready", in_ready, 1);

      // Ordering
      push(3'd7); push(3'd0); push(3'd3);
      repeat (3) handshake();
      check("order_count", grant_count, 3);

      // Full / backpressure
      for (int i = 1; i <= 5; i++) push(3'(i));
      check("full_level", fifo_level, 4);
      check("full_in_ready", in_ready, 0);
      fork
         push(3'd6);
         begin
            repeat (3) @(negedge clk);
            check("held_in_ready", in_ready, 0);
            check("held_level", fifo_level, 4);
            handshake();
         end
      join
      repeat (5) handshake();
      check("drained_level", fifo_level, 0);

      // Held ack keeps WAIT_REL
      push(3'd2); push(3'd4);
      wait_grant();
      ack = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("held_ack_valid", grant_valid, 0);
      end
      exp_cnt = exp_cnt + 8'd1;
      check("held_ack_count", grant_count, exp_cnt);
      ack = 1'b0;
      @(negedge clk);
      check("release_regrant", grant_valid, 1);
      check("release_idx", grant_idx, 4);
      handshake();

      // Counter wrap on the CNT_W=2 instance
      for (int i = 0; i < 5; i++) begin
         int n = 0;
         logic [7:0] oh;
         w_in_idx   = 3'(i);
         w_in_valid = 1'b1;
         @(negedge clk);
         w_in_valid = 1'b0;
         while (!w_grant_valid && n < 20) begin
            @(negedge clk);
            n++;
         end
         oh = 8'b1 << i;
         check("wrap_grant", w_grant, oh);
         w_ack = 1'b1;
         @(negedge clk);
         check("wrap_count", w_grant_count, wrap_exp[i]);
         $display("wrap handshake %0d count=%0d", i, w_grant_count);
         w_ack = 1'b0;
         @(negedge clk);
      end

      repeat (3) @(negedge clk);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
